// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
// Module   : piso_serializer
// Brief    : Parallel-in/serial-out shifter with valid/ready load, pacing
//            enable, selectable bit order and a per-word done pulse.
// Revision : 1.0  initial release
// ============================================================================
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             ser_en,
    output logic             out,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);

    localparam int             C_CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [C_CW-1:0] C_LAST = C_CW'(WIDTH - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic [C_CW-1:0]  cnt_q;
    logic             done_q;

    logic w_shift;
    logic w_last;
    logic w_head;

    assign w_shift = (state_q == S_SHIFT);
    assign w_last  = w_shift && ser_en && (cnt_q == C_LAST);

    // The output end of the shift register depends on the configured bit order
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_head  = shreg_q[WIDTH-1];
            assign shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        end else begin : g_lsb_first
            assign w_head  = shreg_q[0];
            assign shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
        end
    endgenerate

    // rst gates the combinational outputs so they drop the instant it rises
    assign load_ready = !rst && (!w_shift || w_last);
    assign out_valid  = !rst && w_shift;
    assign busy       = out_valid;
    assign out        = !rst && w_shift && w_head;
    assign done       = done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= w_last;
            case (state_q)
                S_IDLE: begin
                    if (load_valid) begin
                        shreg_q <= data;
                        cnt_q   <= '0;
                        state_q <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (ser_en) begin
                        if (cnt_q == C_LAST) begin
                            // Reload on the last-bit edge keeps words back-to-back
                            if (load_valid) begin
                                shreg_q <= data;
                                cnt_q   <= '0;
                            end else begin
                                shreg_q <= '0;
                                cnt_q   <= '0;
                                state_q <= S_IDLE;
                            end
                        end else begin
                            shreg_q <= shreg_d;
                            cnt_q   <= cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_piso_serializer
// Brief    : Four serializer configurations driven against a bit-queue model.
// Revision : 1.0  initial release
// ============================================================================
module tb_piso_serializer;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  dat [N];
    logic [N-1:0] lv, se, lr, ob, ov, bz, dn;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(8),  .MSB_FIRST(1'b0)) u_l8  (.clk(clk), .rst(rst), .data(dat[0][7:0]),
        .load_valid(lv[0]), .load_ready(lr[0]), .ser_en(se[0]), .out(ob[0]), .out_valid(ov[0]), .busy(bz[0]), .done(dn[0]));
    piso_serializer #(.WIDTH(8),  .MSB_FIRST(1'b1)) u_m8  (.clk(clk), .rst(rst), .data(dat[1][7:0]),
        .load_valid(lv[1]), .load_ready(lr[1]), .ser_en(se[1]), .out(ob[1]), .out_valid(ov[1]), .busy(bz[1]), .done(dn[1]));
    piso_serializer #(.WIDTH(2),  .MSB_FIRST(1'b0)) u_l2  (.clk(clk), .rst(rst), .data(dat[2][1:0]),
        .load_valid(lv[2]), .load_ready(lr[2]), .ser_en(se[2]), .out(ob[2]), .out_valid(ov[2]), .busy(bz[2]), .done(dn[2]));
    piso_serializer #(.WIDTH(32), .MSB_FIRST(1'b0)) u_l32 (.clk(clk), .rst(rst), .data(dat[3]),
        .load_valid(lv[3]), .load_ready(lr[3]), .ser_en(se[3]), .out(ob[3]), .out_valid(ov[3]), .busy(bz[3]), .done(dn[3]));

    int width [N] = '{8, 8, 2, 32};
    bit msbf  [N] = '{1'b0, 1'b1, 1'b0, 1'b0};

    // Model: the bits still to be emitted, in emission order
    bit          mq    [N][$];
    bit          obits [N][$];
    logic [31:0] sbq   [N][$];
    bit          cap   [N][$];
    bit   [N-1:0] mdone;
    bit   [N-1:0] lacc;
    int          ndone [N];
    int          total = 0;
    int          bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] wmask(input int w);
        return (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    endfunction

    function automatic logic [31:0] pack_cap(input int i);
        logic [31:0] v = '0;
        foreach (cap[i][j]) v = {v[30:0], cap[i][j]};
        return v;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            mq[i].delete();
            obits[i].delete();
            sbq[i].delete();
        end
        mdone = '0;
        lacc  = '0;
    endtask

    // Called just after a rising edge with inputs already driven
    task automatic step();
        bit [N-1:0]  acc;
        bit [N-1:0]  nd;
        bit          elr;
        int          sz;
        logic [31:0] w;
        logic [31:0] d;
        #4;
        for (int i = 0; i < N; i++) begin
            sz  = mq[i].size();
            elr = !rst && (sz == 0 || (sz == 1 && se[i]));
            check($sformatf("load_ready[%0d]", i), {31'd0, lr[i]}, {31'd0, elr});
            check($sformatf("out_valid[%0d]", i), {31'd0, ov[i]}, {31'd0, sz > 0});
            check($sformatf("busy[%0d]", i), {31'd0, bz[i]}, {31'd0, sz > 0});
            check($sformatf("out[%0d]", i), {31'd0, ob[i]}, {31'd0, (sz > 0) ? mq[i][0] : 1'b0});
            check($sformatf("done[%0d]", i), {31'd0, dn[i]}, {31'd0, mdone[i]});
            if (dn[i]) ndone[i]++;
            if (ov[i] && se[i]) cap[i].push_back(ob[i]);
            acc[i] = lv[i] && elr;
            nd[i]  = (sz == 1) && se[i];
            if (sz > 0 && se[i]) begin
                void'(mq[i].pop_front());
                obits[i].push_back(ob[i]);
                if (obits[i].size() == width[i]) begin
                    w = '0;
                    for (int j = 0; j < width[i]; j++) begin
                        if (msbf[i]) w[width[i]-1-j] = obits[i][j];
                        else         w[j]            = obits[i][j];
                    end
                    obits[i].delete();
                    if (sbq[i].size() == 0) check($sformatf("word_extra[%0d]", i), w, 32'hDEAD_BEEF);
                    else                    check($sformatf("word[%0d]", i), w, sbq[i].pop_front());
                end
            end
            if (acc[i]) begin
                d = dat[i] & wmask(width[i]);
                sbq[i].push_back(d);
                for (int j = 0; j < width[i]; j++)
                    mq[i].push_back(msbf[i] ? d[width[i]-1-j] : d[j]);
            end
        end
        @(posedge clk);
        #1;
        mdone = nd;
        lacc  = acc;
    endtask

    task automatic drain();
        int k = 0;
        lv = '0;
        se = '1;
        while ((mq[0].size() + mq[1].size() + mq[2].size() + mq[3].size()) != 0 && k < 40) begin
            step();
            k++;
        end
        check("drain_timeout", k, (k < 40) ? k : 0);
        step();
        for (int i = 0; i < N; i++) begin
            cap[i].delete();
            ndone[i] = 0;
        end
    endtask

    initial begin
        int drops;
        int vcyc;
        int k;
        rst = 1'b1;
        lv  = '0;
        se  = '0;
        for (int i = 0; i < N; i++) dat[i] = '0;
        model_clear();
        #2;
        check("rst_ready", {28'd0, lr}, 32'd0);
        check("rst_valid", {28'd0, ov}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("post_rst_ready", {28'd0, lr}, 32'hF);

        // LSB-first and MSB-first 0xA5 with ser_en held high
        drain();
        lv[0] = 1'b1; lv[1] = 1'b1; dat[0] = 32'hA5; dat[1] = 32'hA5;
        step();
        lv = '0;
        for (int c = 0; c < 9; c++) step();
        check("a5_lsb_seq", pack_cap(0), 32'hA5);
        check("a5_msb_seq", pack_cap(1), 32'hA5);
        check("a5_lsb_done", ndone[0], 1);
        check("a5_msb_done", ndone[1], 1);
        check("a5_ready_back", {31'd0, lr[0]}, 32'd1);

        // Back-to-back 0x0F then 0xF0, load_valid held throughout
        drain();
        lv[0] = 1'b1; dat[0] = 32'h0F;
        step();
        dat[0] = 32'hF0;
        drops = 0;
        for (int c = 0; c < 16; c++) begin
            if (!ov[0]) drops++;
            step();
            if (lacc[0]) lv[0] = 1'b0;
        end
        step();
        check("b2b_seq", pack_cap(0), 32'hF00F);
        check("b2b_done", ndone[0], 2);
        check("b2b_drops", drops, 0);

        // Stall: 0x81, ser_en low for 3 cycles once bit 2 is on the line
        drain();
        lv[0] = 1'b1; dat[0] = 32'h81;
        step();
        lv[0] = 1'b0;
        vcyc = 0;
        for (int c = 0; c < 12; c++) begin
            se[0] = !(c >= 2 && c <= 4);
            if (ov[0]) vcyc++;
            step();
        end
        check("stall_seq", pack_cap(0), 32'h81);
        check("stall_len", vcyc, 11);
        check("stall_done", ndone[0], 1);

        // Asynchronous reset in the middle of a word
        drain();
        lv[0] = 1'b1; dat[0] = 32'h3C;
        step();
        lv[0] = 1'b0;
        step();
        step();
        #2 rst = 1'b1;
        #1;
        check("mid_rst_out", {31'd0, ob[0]}, 32'd0);
        check("mid_rst_valid", {28'd0, ov}, 32'd0);
        check("mid_rst_busy", {28'd0, bz}, 32'd0);
        check("mid_rst_ready", {28'd0, lr}, 32'd0);
        check("mid_rst_done", {28'd0, dn}, 32'd0);
        model_clear();
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("rel_ready", {31'd0, lr[0]}, 32'd1);
        lv[0] = 1'b1; dat[0] = 32'h96;
        step();
        check("rel_accept", {31'd0, lacc[0]}, 32'd1);
        lv[0] = 1'b0;

        // Randomised traffic on all four configurations
        k = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!lv[i] || lacc[i]) begin
                    lv[i]  = ($urandom_range(0, 3) != 0);
                    dat[i] = $urandom;
                end
                se[i] = (c % 500 < 100) ? 1'b1 : ($urandom_range(0, 3) != 0);
            end
            step();
        end
        drain();
        for (int i = 0; i < N; i++)
            check($sformatf("sb_empty[%0d]", i), sbq[i].size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
